// File: rtl/vga_pkg.sv
//============================================================================
// Module  : vga_pkg
// Purpose : Shared VGA timing defaults, pixel width and framebuffer sizing.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int VGA_COLOR_W  = 3;
  localparam int CNT_W        = 10;

  // Address width for a framebuffer of (h>>shift) x (v>>shift) cells.
  function automatic int fb_addr_w(input int h_act, input int v_act, input int shift);
    int depth;
    depth = (h_act >> shift) * (v_act >> shift);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing_gen.sv
//============================================================================
// Module  : vga_timing_gen
// Purpose : Pixel-tick toggle, raster counters and raw sync/active flags.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             pix_en_o,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output logic             hs_n_o,
  output logic             vs_n_o,
  output logic             active_o,
  output logic             vblank_o
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic             pix_en_q, pix_en_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pix_en_q <= 1'b0;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
    end else begin
      pix_en_q <= pix_en_d;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
    end
  end

  // Counters only move on the clocks where the pixel tick is high.
  always_comb begin
    pix_en_d = ~pix_en_q;
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    if (pix_en_q) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
      end
    end
  end

  assign pix_en_o = pix_en_q;
  assign h_cnt_o  = h_cnt_q;
  assign v_cnt_o  = v_cnt_q;
  assign hs_n_o   = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
  assign vs_n_o   = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
  assign active_o = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign vblank_o = (v_cnt_q >= V_ACT);

endmodule

`default_nettype wire

// File: rtl/vga_scanout.sv
//============================================================================
// Module  : vga_scanout
// Purpose : Pixel-write framebuffer with raster scan-out to VGA DAC pins.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module vga_scanout
  import vga_pkg::*;
#(
  parameter int SCALE_SHIFT = 0,
  parameter int COLOR_W     = VGA_COLOR_W,
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int H_FP        = VGA_H_FP,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BP        = VGA_H_BP,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int V_FP        = VGA_V_FP,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BP        = VGA_V_BP
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic [COLOR_W-1:0] color,
  input  logic               plot,
  output logic               vblank,
  output logic [7:0]         VGA_R,
  output logic [7:0]         VGA_G,
  output logic [7:0]         VGA_B,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_BLANK_N,
  output logic               VGA_SYNC_N,
  output logic               VGA_CLK
);

  localparam int CELLS_X = H_ACTIVE >> SCALE_SHIFT;
  localparam int DEPTH   = CELLS_X * (V_ACTIVE >> SCALE_SHIFT);
  localparam int ADDR_W  = fb_addr_w(H_ACTIVE, V_ACTIVE, SCALE_SHIFT);
  localparam int LIN_W   = 2 * CNT_W;
  localparam logic [CNT_W-1:0] X_LIM = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] Y_LIM = CNT_W'(V_ACTIVE);

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [CNT_W-1:0] col,
                                                  input logic [CNT_W-1:0] row);
    return ADDR_W'(LIN_W'(row >> SCALE_SHIFT) * LIN_W'(CELLS_X) + LIN_W'(col >> SCALE_SHIFT));
  endfunction

  logic             pix_en;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             hs_raw, vs_raw, act_raw, vb_raw;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk_i    (clock),
    .rst_i    (reset),
    .pix_en_o (pix_en),
    .h_cnt_o  (h_cnt),
    .v_cnt_o  (v_cnt),
    .hs_n_o   (hs_raw),
    .vs_n_o   (vs_raw),
    .active_o (act_raw),
    .vblank_o (vb_raw)
  );

  // Range check is on raw coordinates so an overflowing x never spills into the next row.
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  assign wr_en   = plot && (x < X_LIM) && (y < Y_LIM);
  assign wr_addr = cell_addr(x, y);
  assign rd_addr = act_raw ? cell_addr(h_cnt, v_cnt) : '0;

  logic [COLOR_W-1:0] fb_q [DEPTH];
  logic [COLOR_W-1:0] rd_data_q;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      fb_q[wr_addr] <= color;
    end
    rd_data_q <= fb_q[rd_addr];
  end

  logic        hs1_q, vs1_q, act1_q, vb1_q;
  logic        hs_q, vs_q, blank_n_q, vblank_q;
  logic [23:0] rgb_q;

  // Control flags ride alongside the RAM read so every pin lands on the same clock.
  always_ff @(posedge clock) begin
    if (reset) begin
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      act1_q    <= 1'b0;
      vb1_q     <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      vblank_q  <= 1'b0;
      rgb_q     <= '0;
    end else begin
      hs1_q     <= hs_raw;
      vs1_q     <= vs_raw;
      act1_q    <= act_raw;
      vb1_q     <= vb_raw;
      hs_q      <= hs1_q;
      vs_q      <= vs1_q;
      blank_n_q <= act1_q;
      vblank_q  <= vb1_q;
      rgb_q     <= act1_q ? {{8{rd_data_q[COLOR_W-1]}},
                             {8{rd_data_q[COLOR_W-2]}},
                             {8{rd_data_q[COLOR_W-3]}}} : 24'h0;
    end
  end

  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign vblank      = vblank_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_CLK     = pix_en;

endmodule

`default_nettype wire

// File: tb/tb_vga_scanout.sv
//============================================================================
// Module  : tb_vga_scanout
// Purpose : Self-checking bench for vga_scanout against a raster/pixel model.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module tb_vga_scanout;

  localparam int HA = 32, HF = 4, HSY = 8, HB = 6, HT = HA + HF + HSY + HB;
  localparam int VA = 24, VF = 2, VSY = 2, VB = 3, VT = VA + VF + VSY + VB;
  localparam int FRAME_CLK = 2 * HT * VT;
  localparam logic [28:0] RST_VEC = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [9:0] x, y;
  logic [2:0] color;
  logic       plot;

  logic       s_vb, s_hs, s_vs, s_bn, s_sn, s_ck;
  logic [7:0] s_r, s_g, s_b;
  logic       q_vb, q_hs, q_vs, q_bn, q_sn, q_ck;
  logic [7:0] q_r, q_g, q_b;
  logic       f_vb, f_hs, f_vs, f_bn, f_sn, f_ck;
  logic [7:0] f_r, f_g, f_b;

  logic [28:0] s_vec, q_vec, f_vec;
  assign s_vec = {s_ck, s_hs, s_vs, s_bn, s_vb, s_r, s_g, s_b};
  assign q_vec = {q_ck, q_hs, q_vs, q_bn, q_vb, q_r, q_g, q_b};
  assign f_vec = {f_ck, f_hs, f_vs, f_bn, f_vb, f_r, f_g, f_b};

  vga_scanout #(
    .SCALE_SHIFT(0), .COLOR_W(3),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
  ) dut_s (
    .clock(clk), .reset(reset), .x(x), .y(y), .color(color), .plot(plot),
    .vblank(s_vb), .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b), .VGA_HS(s_hs), .VGA_VS(s_vs),
    .VGA_BLANK_N(s_bn), .VGA_SYNC_N(s_sn), .VGA_CLK(s_ck)
  );

  vga_scanout #(
    .SCALE_SHIFT(2), .COLOR_W(3),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
  ) dut_q (
    .clock(clk), .reset(reset), .x(x), .y(y), .color(color), .plot(plot),
    .vblank(q_vb), .VGA_R(q_r), .VGA_G(q_g), .VGA_B(q_b), .VGA_HS(q_hs), .VGA_VS(q_vs),
    .VGA_BLANK_N(q_bn), .VGA_SYNC_N(q_sn), .VGA_CLK(q_ck)
  );

  vga_scanout dut_f (
    .clock(clk), .reset(reset), .x(x), .y(y), .color(color), .plot(plot),
    .vblank(f_vb), .VGA_R(f_r), .VGA_G(f_g), .VGA_B(f_b), .VGA_HS(f_hs), .VGA_VS(f_vs),
    .VGA_BLANK_N(f_bn), .VGA_SYNC_N(f_sn), .VGA_CLK(f_ck)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Clocks since reset was last sampled high.
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  logic [2:0] fb0 [HA*VA];
  logic [2:0] fb2 [(HA/4)*(VA/4)];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_write(input int wx, input int wy, input logic [2:0] wc);
    if (wx < HA && wy < VA) begin
      fb0[wy*HA + wx] = wc;
      fb2[(wy/4)*(HA/4) + wx/4] = wc;
    end
  endtask

  // Pins after clock c show the raster position reached two clocks earlier.
  function automatic logic [28:0] exp_vec(input int c, input int s);
    int p, h, v;
    logic bn;
    logic [2:0] col;
    if (c < 2) return {c[0], 1'b1, 1'b1, 1'b0, 1'b0, 24'h0};
    p = (c - 2) / 2;
    h = p % HT;
    v = (p / HT) % VT;
    bn = (h < HA) && (v < VA);
    col = 3'b000;
    if (bn) col = (s == 0) ? fb0[v*HA + h] : fb2[(v/4)*(HA/4) + h/4];
    return {c[0], !(h >= HA+HF && h < HA+HF+HSY), !(v >= VA+VF && v < VA+VF+VSY),
            bn, (v >= VA), {8{col[2]}}, {8{col[1]}}, {8{col[0]}}};
  endfunction

  task automatic drive(input int wx, input int wy, input logic [2:0] wc, input logic wp);
    @(posedge clk);
    #1;
    x = 10'(wx);
    y = 10'(wy);
    color = wc;
    plot = wp;
    if (wp) model_write(wx, wy, wc);
  endtask

  task automatic wait_pin(input int sel, input logic lvl, input int budget, output int at);
    logic v;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      v = (sel == 0) ? f_hs : s_vs;
      if (v == lvl) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic measure_full();
    int t0, t1, t2;
    wait_pin(0, 1'b0, 3000, t0);
    check_val("full_hs_first_fall", 32'(t0), 32'(2*656 + 2));
    wait_pin(0, 1'b1, 400, t1);
    check_val("full_hs_low_clks", 32'(t1 - t0), 32'd192);
    wait_pin(0, 1'b0, 2000, t2);
    check_val("full_hs_period", 32'(t2 - t0), 32'd1600);
  endtask

  task automatic clear_fb();
    for (int yy = 0; yy < VA; yy++)
      for (int xx = 0; xx < HA; xx++)
        drive(xx, yy, 3'b000, 1'b1);
    drive(0, 0, 3'b000, 1'b0);
  endtask

  task automatic scan_frame(input string tag);
    int n_bn, n_vs, n_hs;
    n_bn = 0;
    n_vs = 0;
    n_hs = 0;
    repeat (4) @(posedge clk);
    for (int i = 0; i < FRAME_CLK; i++) begin
      @(negedge clk);
      check_val({tag, "_pins_s0"}, 32'(s_vec), 32'(exp_vec(cyc, 0)));
      check_val({tag, "_pins_s2"}, 32'(q_vec), 32'(exp_vec(cyc, 2)));
      n_bn += s_bn ? 1 : 0;
      n_vs += s_vs ? 0 : 1;
      n_hs += s_hs ? 0 : 1;
    end
    check_val({tag, "_blank_n_clks"}, 32'(n_bn), 32'(VA * HA * 2));
    check_val({tag, "_vs_low_clks"}, 32'(n_vs), 32'(VSY * HT * 2));
    check_val({tag, "_hs_low_clks"}, 32'(n_hs), 32'(HSY * 2 * VT));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int at;
    reset = 1'b1;
    plot  = 1'b0;
    x     = '0;
    y     = '0;
    color = '0;
    for (int i = 0; i < HA*VA; i++) fb0[i] = 3'b000;
    for (int i = 0; i < (HA/4)*(VA/4); i++) fb2[i] = 3'b000;

    repeat (5) @(posedge clk);
    @(negedge clk);
    check_val("reset_pins_s0", 32'(s_vec), 32'(RST_VEC));
    check_val("reset_pins_s2", 32'(q_vec), 32'(RST_VEC));
    check_val("reset_pins_full", 32'(f_vec), 32'(RST_VEC));
    check_val("sync_n_tied", 32'({s_sn, q_sn, f_sn}), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    fork
      measure_full();
      clear_fb();
    join

    // Directed: single pixel, out-of-range column, scaled cell, retention marker.
    drive(5, 3, 3'b101, 1'b1);
    drive(HA, 0, 3'b111, 1'b1);
    drive(7, 2, 3'b010, 1'b1);
    drive(10, 10, 3'b001, 1'b1);
    drive(HA + 3, 5, 3'b110, 1'b1);
    drive(3, VA, 3'b111, 1'b1);
    drive(0, 0, 3'b000, 1'b0);
    scan_frame("dir");

    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 60; k++) begin
        if ($urandom_range(3) == 0)
          drive(0, 0, 3'b000, 1'b0);
        else
          drive(int'($urandom_range(HA + 8)), int'($urandom_range(VA + 6)),
                3'($urandom_range(7)), 1'b1);
      end
      drive(0, 0, 3'b000, 1'b0);
      drive(10, 10, 3'b001, 1'b1);
      drive(0, 0, 3'b000, 1'b0);
      scan_frame("rnd");
    end

    // Reset in the middle of a frame, while the scan is on line 15.
    for (int i = 0; i < FRAME_CLK + 10; i++) begin
      @(negedge clk);
      if (cyc >= 2 && (((cyc - 2) / 2) / HT) % VT == 15) break;
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    wait_pin(1, 1'b0, 2 * FRAME_CLK, at);
    check_val("midrst_vs_first_fall", 32'(at), 32'(2 * (VA + VF) * HT + 2));
    scan_frame("rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
